// File: rtl/video_block_locator_if.sv
// Video timing in and per-pixel position tags out for the local-dimming block locator.
// The master drives de/hs/vs; the slave (the locator) returns the registered tags.
interface video_block_locator_if #(
  parameter int CW = 11,
  parameter int BW = 6
);
  logic          de;
  logic          hs;
  logic          vs;
  logic          de_o;
  logic [CW-1:0] x_o;
  logic [CW-1:0] y_o;
  logic [BW-1:0] blk_x;
  logic [BW-1:0] blk_y;
  logic [CW-1:0] in_x;
  logic [CW-1:0] in_y;
  logic          blk_row_end;
  logic          blk_done;
  logic          line_end;
  logic          frame_end;
  logic          fmt_err;

  modport master (
    output de, hs, vs,
    input  de_o, x_o, y_o, blk_x, blk_y, in_x, in_y,
    input  blk_row_end, blk_done, line_end, frame_end, fmt_err
  );

  modport slave (
    input  de, hs, vs,
    output de_o, x_o, y_o, blk_x, blk_y, in_x, in_y,
    output blk_row_end, blk_done, line_end, frame_end, fmt_err
  );
endinterface

// File: rtl/video_block_locator.sv
// Tags each active pixel with absolute, block and in-block coordinates plus boundary strobes.
// Block position is tracked with wrap counters, so no divider or multiplier is needed.
module video_block_locator #(
  parameter int H_ACT = 1280,
  parameter int V_ACT = 720,
  parameter int BLK_W = 32,
  parameter int BLK_H = 36,
  parameter int CW    = 11,
  parameter int BW    = 6
) (
  input  logic                    pclk,
  input  logic                    rstn,
  video_block_locator_if.slave    bus
);

  localparam logic [CW-1:0] H_END  = CW'(H_ACT);
  localparam logic [CW-1:0] V_END  = CW'(V_ACT);
  localparam logic [CW-1:0] H_LAST = CW'(H_ACT - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_ACT - 1);
  localparam logic [CW-1:0] BW_LAST = CW'(BLK_W - 1);
  localparam logic [CW-1:0] BH_LAST = CW'(BLK_H - 1);

  logic [CW-1:0] xc_q, xc_d, yc_q, yc_d, ixc_q, ixc_d, iyc_q, iyc_d;
  logic [BW-1:0] bxc_q, bxc_d, byc_q, byc_d;
  logic          de_q, de_d, lineAcc_q, lineAcc_d, fmtErr_q, fmtErr_d;

  logic          deOut_q, deOut_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d, inX_q, inX_d, inY_q, inY_d;
  logic [BW-1:0] blkX_q, blkX_d, blkY_q, blkY_d;
  logic          rowEnd_q, rowEnd_d, done_q, done_d;
  logic          lineEnd_q, lineEnd_d, frameEnd_q, frameEnd_d;

  logic          deFall, accept, rowEnd, colBottom;

  assign deFall    = de_q & ~bus.de;
  assign accept    = bus.de && (xc_q < H_END) && (yc_q < V_END);
  assign rowEnd    = (ixc_q == BW_LAST) || (xc_q == H_LAST);
  assign colBottom = (iyc_q == BH_LAST) || (yc_q == V_LAST);

  always_comb begin
    xc_d       = xc_q;
    yc_d       = yc_q;
    ixc_d      = ixc_q;
    iyc_d      = iyc_q;
    bxc_d      = bxc_q;
    byc_d      = byc_q;
    de_d       = bus.de;
    lineAcc_d  = lineAcc_q;
    fmtErr_d   = fmtErr_q;
    deOut_d    = 1'b0;
    x_d        = x_q;
    y_d        = y_q;
    inX_d      = inX_q;
    inY_d      = inY_q;
    blkX_d     = blkX_q;
    blkY_d     = blkY_q;
    rowEnd_d   = 1'b0;
    done_d     = 1'b0;
    lineEnd_d  = 1'b0;
    frameEnd_d = 1'b0;

    if (bus.vs) begin
      xc_d      = '0;
      yc_d      = '0;
      ixc_d     = '0;
      iyc_d     = '0;
      bxc_d     = '0;
      byc_d     = '0;
      de_d      = 1'b0;
      lineAcc_d = 1'b0;
      fmtErr_d  = 1'b0;
    end else begin
      // A de fall closes the line even when hs arrives in the same cycle.
      if (deFall) begin
        if (lineAcc_q && (xc_q != H_END)) fmtErr_d = 1'b1;
        xc_d      = '0;
        ixc_d     = '0;
        bxc_d     = '0;
        lineAcc_d = 1'b0;
        if (yc_q < V_END) begin
          yc_d = yc_q + 1'b1;
          if (colBottom) begin
            iyc_d = '0;
            byc_d = byc_q + 1'b1;
          end else begin
            iyc_d = iyc_q + 1'b1;
          end
        end
      end

      if (bus.hs) begin
        xc_d  = '0;
        ixc_d = '0;
        bxc_d = '0;
      end else if (accept) begin
        deOut_d    = 1'b1;
        x_d        = xc_q;
        y_d        = yc_q;
        inX_d      = ixc_q;
        inY_d      = iyc_q;
        blkX_d     = bxc_q;
        blkY_d     = byc_q;
        rowEnd_d   = rowEnd;
        done_d     = rowEnd && colBottom;
        lineEnd_d  = (xc_q == H_LAST);
        frameEnd_d = (xc_q == H_LAST) && (yc_q == V_LAST);
        lineAcc_d  = 1'b1;
        xc_d       = xc_q + 1'b1;
        if (rowEnd) begin
          ixc_d = '0;
          bxc_d = bxc_q + 1'b1;
        end else begin
          ixc_d = ixc_q + 1'b1;
        end
      end else if (bus.de) begin
        fmtErr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!rstn) begin
      xc_q       <= '0;
      yc_q       <= '0;
      ixc_q      <= '0;
      iyc_q      <= '0;
      bxc_q      <= '0;
      byc_q      <= '0;
      de_q       <= 1'b0;
      lineAcc_q  <= 1'b0;
      fmtErr_q   <= 1'b0;
      deOut_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      inX_q      <= '0;
      inY_q      <= '0;
      blkX_q     <= '0;
      blkY_q     <= '0;
      rowEnd_q   <= 1'b0;
      done_q     <= 1'b0;
      lineEnd_q  <= 1'b0;
      frameEnd_q <= 1'b0;
    end else begin
      xc_q       <= xc_d;
      yc_q       <= yc_d;
      ixc_q      <= ixc_d;
      iyc_q      <= iyc_d;
      bxc_q      <= bxc_d;
      byc_q      <= byc_d;
      de_q       <= de_d;
      lineAcc_q  <= lineAcc_d;
      fmtErr_q   <= fmtErr_d;
      deOut_q    <= deOut_d;
      x_q        <= x_d;
      y_q        <= y_d;
      inX_q      <= inX_d;
      inY_q      <= inY_d;
      blkX_q     <= blkX_d;
      blkY_q     <= blkY_d;
      rowEnd_q   <= rowEnd_d;
      done_q     <= done_d;
      lineEnd_q  <= lineEnd_d;
      frameEnd_q <= frameEnd_d;
    end
  end

  assign bus.de_o        = deOut_q;
  assign bus.x_o         = x_q;
  assign bus.y_o         = y_q;
  assign bus.blk_x       = blkX_q;
  assign bus.blk_y       = blkY_q;
  assign bus.in_x        = inX_q;
  assign bus.in_y        = inY_q;
  assign bus.blk_row_end = rowEnd_q;
  assign bus.blk_done    = done_q;
  assign bus.line_end    = lineEnd_q;
  assign bus.frame_end   = frameEnd_q;
  assign bus.fmt_err     = fmtErr_q;

endmodule

// File: doc/video_block_locator.md
# video_block_locator

Parametrised pixel/line/block position generator for the local-dimming statistics path. Sits directly after the video input timing (de/hs/vs) and ahead of the per-block mean accumulators. Tags every active pixel with absolute coordinates, block indices, in-block coordinates and block/line/frame boundary strobes, all in the pixel clock domain. Supports any active size and block size, including partial edge blocks, and flags malformed frames.

## Interface
- `H_ACT`, 1280: active pixels per line.
- `V_ACT`, 720: active lines per frame.
- `BLK_W`, 32: block width in pixels.
- `BLK_H`, 36: block height in lines.
- `CW`, 11: coordinate width; requires 2^CW > max(H_ACT, V_ACT).
- `BW`, 6: block index width; requires 2^BW ≥ ceil(H_ACT/BLK_W) and 2^BW ≥ ceil(V_ACT/BLK_H).
- `pclk`  in  1  pixel clock; the only clock.
- `rstn`  in  1  reset; synchronous, active-low.
- `de`  in  1  data enable, active-high.
- `hs`  in  1  horizontal sync, active-high.
- `vs`  in  1  vertical sync, active-high.
- `de_o`  out  1  valid pixel tag; `de` delayed 1 cycle, qualified.
- `x_o`  out  CW  pixel column, 0-based.
- `y_o`  out  CW  pixel line, 0-based.
- `blk_x`  out  BW  horizontal block index, 0-based.
- `blk_y`  out  BW  vertical block index, 0-based.
- `in_x`  out  BW+? → CW  column within block, 0..BLK_W-1.
- `in_y`  out  CW  line within block, 0..BLK_H-1.
- `blk_row_end`  out  1  last pixel of current block on this line.
- `blk_done`  out  1  last pixel of the whole block (bottom-right).
- `line_end`  out  1  last accepted pixel of a line (x_o = H_ACT-1).
- `frame_end`  out  1  last pixel of frame (x_o = H_ACT-1, y_o = V_ACT-1).
- `fmt_err`  out  1  sticky format error; cleared on `vs`.

## Operation
- Internal next-position state: `xc`, `yc`, `ixc`, `iyc`, `bxc`, `byc`. Block tracking is incremental; no divider or multiplier.
- Priority each cycle: `rstn`=0 > `vs` > `hs` > `de`.
- `vs`=1:
  - Clear all next-position state and `fmt_err`.
  - `de_o`=0 even if `de`=1; that pixel is discarded.
- `hs`=1: clear `xc`, `ixc`, `bxc` only.
- `de`=1 with `xc`<H_ACT and `yc`<V_ACT (accepted pixel):
  - Register current position to the outputs and set `de_o`=1.
  - Increment `xc`.
  - Increment `ixc`. When `ixc`=BLK_W-1 or `xc`=H_ACT-1, set `ixc` to 0 and increment `bxc`.
- `de`=1 outside the active range: pixel dropped, `de_o`=0, `fmt_err` set.
- End of line (`de` fall, detected from registered `de`):
  - If the line had any accepted pixels and `xc`≠H_ACT (short line), set `fmt_err`.
  - Clear `xc`, `ixc`, `bxc`.
  - Increment `yc`. `iyc` wraps at BLK_H-1 or at `yc`=V_ACT-1, and `byc` increments on that wrap.
- Strobes are valid only with `de_o`=1:
  - `blk_row_end` = (`in_x`=BLK_W-1) or (`x_o`=H_ACT-1).
  - `blk_done` = `blk_row_end` and ((`in_y`=BLK_H-1) or (`y_o`=V_ACT-1)).
  - `line_end` = (`x_o`=H_ACT-1).
  - `frame_end` = `line_end` and (`y_o`=V_ACT-1).
- Partial edge blocks: the last block column/row is narrower/shorter. The strobes still fire on its last pixel.
- All outputs reset to 0 (`de_o`, coordinates, indices, strobes, `fmt_err`).

## Timing
- Latency is exactly 1 `pclk` from `de` to every output.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Strobes are single-cycle and coincide with the tagged pixel.
- Between accepted pixels the outputs hold their last value, with `de_o`=0 and all strobes 0.
- Reset mid-line: next cycle all outputs are 0. The first `de` after release is treated as x=0, y=0.
- `vs` and `de` asserted in the same cycle: `vs` wins.
- `hs` asserted during `de`: the line restarts at x=0 on the next cycle. `fmt_err` is set at the `de` fall because the line is short.

## Test plan
- H_ACT=1280, V_ACT=720, BLK 32x36; one full frame -> 921600 `de_o` pulses; `blk_done` count 800; last `blk_done` at blk_x=39, blk_y=19; single `frame_end` at (1279,719); `fmt_err`=0.
- Partial blocks: H_ACT=100, V_ACT=50, BLK 32x16 -> `blk_row_end` at x=31,63,95,99; `blk_done` at y=15,31,47,49; blk_x max 3, blk_y max 3.
- Short line of 1000 pixels on line 5 -> `fmt_err` rises 1 cycle after the `de` fall; stays high until `vs`; line 6 starts at x=0, y=6.
- `de` held 1290 pixels -> pixels 1280..1289 give `de_o`=0; `fmt_err`=1; `line_end` fires once at x=1279.
- `rstn` low for 1 cycle at pixel (640,300) -> next cycle all outputs 0; the following `de` tags (0,0) with blk 0,0.
- `vs` coincident with `de` -> `de_o`=0 for that pixel; `fmt_err` cleared; the next line tags y=0.
